// File: rtl/common.sv
// Shared posit datapath types and helpers.
package common;

    typedef enum logic {
        POS = 1'b0,
        NEG = 1'b1
    } sign_t;

    localparam int unsigned SCALE_W = 9;
    localparam int unsigned MANT_W  = 8;

    // Normalised sum as held between the normalise and encode stages.
    typedef struct packed {
        sign_t                      sign;
        logic                       zero;
        logic                       nar;
        logic signed [SCALE_W-1:0]  scale;
        logic [MANT_W-1:0]          mant;
        logic                       sticky;
    } unpacked_posit_t;

    // Largest positive posit of the given width: 0 followed by all ones.
    function automatic logic [31:0] maxpos(input int width);
        return (32'd1 << (width - 1)) - 32'd1;
    endfunction

    // NaR: 1 followed by all zeros.
    function automatic logic [31:0] nar_pattern(input int width);
        return 32'd1 << (width - 1);
    endfunction

endpackage

// File: rtl/posit_lzc.sv
// Combinational leading-zero counter; an all-zero input counts MW.
module posit_lzc #(
    parameter int MW = 8
) (
    input  logic [MW-1:0]              value,
    output logic [$clog2(MW+1)-1:0]    count
);

    logic found;

    // Scan from the MSB, counting zeros until the first one.
    always_comb begin
        count = '0;
        found = 1'b0;
        for (int i = MW - 1; i >= 0; i--) begin
            if (!found) begin
                if (value[i]) begin
                    found = 1'b1;
                end else begin
                    count = count + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/posit_result_encoder.sv
// Posit adder output stage: normalise (S1), round/saturate/pack (S2), valid/ready pipeline.
// Optional feature macro: POSIT_ENC_SAT_FLAG_EN adds out_sat (result clamped to maxpos/minpos).
module posit_result_encoder
    import common::*;
#(
    parameter int WIDTH = 7,
    parameter int EN    = 1,
    parameter int MW    = 8   // must match common::MANT_W (S1 register layout)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  sign_t            in_sign,
    input  logic             in_zero,
    input  logic             in_nar,
    input  logic [7:0]       in_scale,
    input  logic [MW-1:0]    in_mant,
    input  logic             in_sticky,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_posit
`ifdef POSIT_ENC_SAT_FLAG_EN
    ,
    output logic             out_sat
`endif
);

    localparam int LZW = $clog2(MW + 1);
    localparam int FW  = 2 * WIDTH;
    localparam int TW  = EN + MW - 1;

    logic [LZW-1:0]            lzc;
    unpacked_posit_t           s1_d, s1_q;
    logic                      s1_v, s2_v, s2_ready;
    logic [WIDTH-1:0]          posit_d, posit_q;

    logic signed [SCALE_W-1:0] scale_s;
    int                        k, reg_len;
    logic [EN-1:0]             e;
    logic [TW-1:0]             tail;
    logic [FW-1:0]             tail_ext, regime, field;
    logic [WIDTH-2:0]          body, mag;
    logic [WIDTH-1:0]          sum;
    logic                      guard, rest_sticky, rnd_up, sat_hi, sat_lo, is_zero;
`ifdef POSIT_ENC_SAT_FLAG_EN
    logic                      sat_d, sat_q;
`endif

    posit_lzc #(.MW(MW)) u_lzc (
        .value (in_mant),
        .count (lzc)
    );

    assign s2_ready  = !s2_v || out_ready;
    assign in_ready  = !s1_v || s2_ready;
    assign out_valid = s2_v;
    assign out_posit = posit_q;
`ifdef POSIT_ENC_SAT_FLAG_EN
    assign out_sat   = sat_q;
`endif

    // S1 next state: shift out leading zeros and compensate the scale.
    always_comb begin
        s1_d.sign   = in_sign;
        s1_d.nar    = in_nar;
        s1_d.zero   = in_zero || (in_mant == '0);
        s1_d.scale  = {in_scale[7], in_scale} - SCALE_W'(lzc);
        s1_d.mant   = in_mant << lzc;
        s1_d.sticky = in_sticky;
    end

    // S1 register: reloads whenever the stage can accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_v <= 1'b0;
            s1_q <= '0;
        end else if (in_ready) begin
            s1_v <= in_valid;
            if (in_valid) begin
                s1_q <= s1_d;
            end
        end
    end

    // S2 encode: build regime|exponent|fraction bit string, round to nearest even, clamp, sign.
    always_comb begin
        scale_s  = s1_q.scale;
        k        = int'(scale_s >>> EN);
        e        = scale_s[EN-1:0];
        tail     = {e, s1_q.mant[MW-2:0]};
        tail_ext = {tail, {(FW - TW){1'b0}}};
        sat_hi   = k > (WIDTH - 3);
        sat_lo   = k < -(WIDTH - 2);
        if (k >= 0) begin
            reg_len = k + 2;
            regime  = ~({FW{1'b1}} >> (k + 1));
        end else begin
            reg_len = 1 - k;
            regime  = {1'b1, {(FW - 1){1'b0}}} >> (reg_len - 1);
        end
        field       = (tail_ext >> reg_len) | regime;
        body        = field[FW-1 -: WIDTH-1];
        guard       = field[FW-WIDTH];
        rest_sticky = (|field[FW-WIDTH-1:0]) || s1_q.sticky;
        rnd_up      = guard && (body[0] || rest_sticky);
        sum         = {1'b0, body} + {{(WIDTH - 1){1'b0}}, rnd_up};
        if (sat_lo) begin
            mag = (WIDTH - 1)'(1);
        end else if (sat_hi || sum[WIDTH-1]) begin
            mag = (WIDTH - 1)'(maxpos(WIDTH));
        end else begin
            mag = sum[WIDTH-2:0];
        end
        posit_d = {1'b0, mag};
        if (s1_q.sign == NEG) begin
            posit_d = -posit_d;
        end
        // A mantissa without its hidden bit after normalisation can only be zero.
        is_zero = s1_q.zero || !s1_q.mant[MW-1];
`ifdef POSIT_ENC_SAT_FLAG_EN
        sat_d = sat_hi || sat_lo || sum[WIDTH-1];
`endif
        if (s1_q.nar) begin
            posit_d = WIDTH'(nar_pattern(WIDTH));
`ifdef POSIT_ENC_SAT_FLAG_EN
            sat_d   = 1'b0;
`endif
        end else if (is_zero) begin
            posit_d = '0;
`ifdef POSIT_ENC_SAT_FLAG_EN
            sat_d   = 1'b0;
`endif
        end
    end

    // S2 register: holds the output while downstream stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_v    <= 1'b0;
            posit_q <= '0;
`ifdef POSIT_ENC_SAT_FLAG_EN
            sat_q   <= 1'b0;
`endif
        end else if (s2_ready) begin
            s2_v <= s1_v;
            if (s1_v) begin
                posit_q <= posit_d;
`ifdef POSIT_ENC_SAT_FLAG_EN
                sat_q   <= sat_d;
`endif
            end
        end
    end

endmodule
